// File: rtl/cpu_pkg.sv
// Shared CPU types: register numbers, the zero register and per-op control fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_NUM_REGS = 32;
  localparam int CPU_AW       = $clog2(CPU_NUM_REGS);

  typedef logic [CPU_AW-1:0] reg_addr_t;

  // Highest register number is hardwired to zero.
  localparam reg_addr_t XZR = reg_addr_t'(CPU_NUM_REGS - 1);

  // Control fields carried alongside the resolved operands.
  typedef struct packed {
    reg_addr_t rd;
    logic      writes_rd;
    logic      is_load;
  } op_ctrl_t;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: zero reg / unused, then MEM forward, then WB bypass, then RF.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module operand_bypass #(
  parameter int REG_WIDTH = 64,
  parameter int AW        = 5,
  parameter logic [AW-1:0] ZERO_REG = '1
) (
  input  logic [AW-1:0]        reg_num,
  input  logic                 uses,
  input  logic [REG_WIDTH-1:0] rf_data,
  input  logic                 mem_fwd_valid,
  input  logic [AW-1:0]        mem_fwd_reg,
  input  logic [REG_WIDTH-1:0] mem_fwd_data,
  input  logic                 wb_write,
  input  logic [AW-1:0]        wb_reg,
  input  logic [REG_WIDTH-1:0] wb_data,
  output logic [REG_WIDTH-1:0] value
);

  // Priority mux: the youngest producer wins; the zero register overrides everything.
  always_comb begin
    value = rf_data;
    if (!uses || reg_num == ZERO_REG) begin
      value = '0;
    end else if (mem_fwd_valid && mem_fwd_reg == reg_num) begin
      value = mem_fwd_data;
    end else if (wb_write && wb_reg == reg_num) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Operand stage: resolves both source operands and holds them in a valid/ready register.
// Latency: one cycle from input capture to out_valid.
// Backpressure: in_ready drops when the held op is not taken, on a load-use hazard, or on flush.
module operand_stage
  import cpu_pkg::*;
#(
  parameter int REG_WIDTH  = 64,
  parameter int NUM_REGS   = 32,   // must match CPU_NUM_REGS in cpu_pkg
  parameter int LOAD_STALL = 1     // 1..3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_REGS)-1:0] in_rn,
  input  logic [$clog2(NUM_REGS)-1:0] in_rm,
  input  logic [$clog2(NUM_REGS)-1:0] in_rd,
  input  logic                        in_uses_rn,
  input  logic                        in_uses_rm,
  input  logic                        in_writes_rd,
  input  logic                        in_is_load,
  output logic [$clog2(NUM_REGS)-1:0] rf_read_reg1,
  output logic [$clog2(NUM_REGS)-1:0] rf_read_reg2,
  input  logic [REG_WIDTH-1:0]        rf_read_data1,
  input  logic [REG_WIDTH-1:0]        rf_read_data2,
  input  logic                        mem_fwd_valid,
  input  logic [$clog2(NUM_REGS)-1:0] mem_fwd_reg,
  input  logic [REG_WIDTH-1:0]        mem_fwd_data,
  input  logic                        wb_write,
  input  logic [$clog2(NUM_REGS)-1:0] wb_reg,
  input  logic [REG_WIDTH-1:0]        wb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [REG_WIDTH-1:0]        out_op_a,
  output logic [REG_WIDTH-1:0]        out_op_b,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic                        out_writes_rd,
  output logic                        out_is_load
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZERO_REG = AW'(NUM_REGS - 1);

  logic [REG_WIDTH-1:0] res_a;
  logic [REG_WIDTH-1:0] res_b;
  op_ctrl_t             ctrl_q;
  logic [1:0]           load_cnt;
  reg_addr_t            load_rd;
  logic                 hazard;
  logic                 capture;
  logic                 out_hs;
  logic                 load_done;

  assign rf_read_reg1 = in_rn;
  assign rf_read_reg2 = in_rm;

  operand_bypass #(.REG_WIDTH(REG_WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_bypass_a (
    .reg_num(in_rn), .uses(in_uses_rn), .rf_data(rf_read_data1),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .value(res_a)
  );

  operand_bypass #(.REG_WIDTH(REG_WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_bypass_b (
    .reg_num(in_rm), .uses(in_uses_rm), .rf_data(rf_read_data2),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .value(res_b)
  );

  // Hazard only looks at the already-tracked load; a load leaving this very cycle
  // is ordered downstream and starts tracking next cycle.
  assign hazard = (load_cnt != 2'd0) &&
                  ((in_uses_rn && in_rn == load_rd) || (in_uses_rm && in_rm == load_rd));

  assign in_ready  = (!out_valid || out_ready) && !hazard && !flush;
  assign capture   = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign load_done = out_hs && ctrl_q.is_load && ctrl_q.writes_rd && (ctrl_q.rd != ZERO_REG);

  assign out_rd        = ctrl_q.rd;
  assign out_writes_rd = ctrl_q.writes_rd;
  assign out_is_load   = ctrl_q.is_load;

  // Pipeline register: capture resolved operands, hold while stalled, bubble on drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid        <= 1'b1;
      out_op_a         <= res_a;
      out_op_b         <= res_b;
      ctrl_q.rd        <= in_rd;
      ctrl_q.writes_rd <= in_writes_rd;
      ctrl_q.is_load   <= in_is_load;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Load tracking: arm on a load leaving the stage, count down the stall window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt <= 2'd0;
      load_rd  <= '0;
    end else if (flush) begin
      load_cnt <= 2'd0;
    end else if (load_done) begin
      load_cnt <= 2'(LOAD_STALL);
      load_rd  <= ctrl_q.rd;
    end else if (load_cnt != 2'd0) begin
      load_cnt <= load_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage with a scoreboard of expected outputs.
// Latency: expects one cycle capture-to-output.
// Backpressure: drives out_ready low to exercise hold behaviour.
module tb_operand_stage;

  localparam int W  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_rn = '0, in_rm = '0, in_rd = '0;
  logic          in_uses_rn = 1'b0, in_uses_rm = 1'b0, in_writes_rd = 1'b0, in_is_load = 1'b0;
  logic [AW-1:0] rf_read_reg1, rf_read_reg2;
  logic [W-1:0]  rf_read_data1 = '0, rf_read_data2 = '0;
  logic          mem_fwd_valid = 1'b0;
  logic [AW-1:0] mem_fwd_reg = '0;
  logic [W-1:0]  mem_fwd_data = '0;
  logic          wb_write = 1'b0;
  logic [AW-1:0] wb_reg = '0;
  logic [W-1:0]  wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_op_a, out_op_b;
  logic [AW-1:0] out_rd;
  logic          out_writes_rd, out_is_load;

  always #5 clk = ~clk;

  operand_stage #(.REG_WIDTH(W), .NUM_REGS(32), .LOAD_STALL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_uses_rn(in_uses_rn), .in_uses_rm(in_uses_rm),
    .in_writes_rd(in_writes_rd), .in_is_load(in_is_load),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_is_load(out_is_load)
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   st;
  logic ov;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every out handshake pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("op_a", out_op_a, mon_e.a);
        check("op_b", out_op_b, mon_e.b);
        check("rd", 64'(out_rd), 64'(mon_e.rd));
        check("writes_rd", 64'(out_writes_rd), 64'(mon_e.wr));
        check("is_load", 64'(out_is_load), 64'(mon_e.ld));
      end
    end
  end

  // Present one instruction, wait (bounded) for in_ready, push the expected result.
  // Returns the number of stalled cycles and out_valid in the accepting cycle.
  task automatic send(input logic [AW-1:0] rn, input logic [AW-1:0] rm, input logic [AW-1:0] rd,
                      input logic urn, input logic urm, input logic wr, input logic ld,
                      input logic [W-1:0] rf1, input logic [W-1:0] rf2,
                      input logic [W-1:0] ea, input logic [W-1:0] eb,
                      output int stalls, output logic ov_acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    stalls = 0;
    ov_acc = 1'b0;
    in_rn = rn; in_rm = rm; in_rd = rd;
    in_uses_rn = urn; in_uses_rm = urm; in_writes_rd = wr; in_is_load = ld;
    rf_read_data1 = rf1; rf_read_data2 = rf2;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        check("rf_read_reg1", 64'(rf_read_reg1), 64'(rn));
        check("rf_read_reg2", 64'(rf_read_reg2), 64'(rm));
        e.a = ea; e.b = eb; e.rd = rd; e.wr = wr; e.ld = ld;
        sb.push_back(e);
        ov_acc = out_valid;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_op_a", out_op_a, 64'd0);
    check("rst_op_b", out_op_b, 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_ctrl", 64'({out_writes_rd, out_is_load}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Plain register-file reads.
    send(5'd1, 5'd2, 5'd10, 1, 1, 1, 0, 64'h5, 64'h7, 64'h5, 64'h7, st, ov);

    // Same-cycle write-back bypass beats stale RF data.
    wb_write = 1'b1; wb_reg = 5'd3; wb_data = 64'hAA;
    send(5'd3, 5'd2, 5'd11, 1, 1, 1, 0, 64'h11, 64'h7, 64'hAA, 64'h7, st, ov);

    // MEM forward beats WB; both beat RF.
    mem_fwd_valid = 1'b1; mem_fwd_reg = 5'd4; mem_fwd_data = 64'h22;
    wb_reg = 5'd4; wb_data = 64'h33;
    send(5'd4, 5'd2, 5'd12, 1, 1, 1, 0, 64'h44, 64'h7, 64'h22, 64'h7, st, ov);

    // MEM forward on the second operand only.
    mem_fwd_reg = 5'd2; mem_fwd_data = 64'h55; wb_reg = 5'd9;
    send(5'd1, 5'd2, 5'd12, 1, 1, 0, 0, 64'h5, 64'h7, 64'h5, 64'h55, st, ov);

    // X31 reads zero even when both paths forward to it.
    mem_fwd_reg = 5'd31; wb_reg = 5'd31;
    send(5'd31, 5'd31, 5'd13, 1, 1, 1, 0, 64'h99, 64'h98, 64'h0, 64'h0, st, ov);
    mem_fwd_valid = 1'b0; wb_write = 1'b0;

    // Load-use: load X5, independent filler, then a reader of X5.
    send(5'd1, 5'd2, 5'd5, 1, 1, 1, 1, 64'h1, 64'h2, 64'h1, 64'h2, st, ov);
    send(5'd1, 5'd1, 5'd8, 1, 1, 1, 0, 64'h3, 64'h3, 64'h3, 64'h3, st, ov);
    send(5'd5, 5'd1, 5'd9, 1, 1, 1, 0, 64'h50, 64'h6, 64'h50, 64'h6, st, ov);
    check("lu_stall_cycles", 64'(st), 64'd1);
    check("lu_bubble_out_valid", 64'(ov), 64'd0);

    // Load to X31 is not tracked.
    send(5'd1, 5'd2, 5'd31, 1, 1, 1, 1, 64'h1, 64'h2, 64'h1, 64'h2, st, ov);
    send(5'd1, 5'd1, 5'd8, 1, 1, 1, 0, 64'h3, 64'h3, 64'h3, 64'h3, st, ov);
    send(5'd31, 5'd1, 5'd9, 1, 1, 1, 0, 64'h77, 64'h6, 64'h0, 64'h6, st, ov);
    check("x31_load_stall", 64'(st), 64'd0);
    check("x31_load_no_bubble", 64'(ov), 64'd1);

    // Load to X6, reader has X6 as an unused operand.
    send(5'd1, 5'd2, 5'd6, 1, 1, 1, 1, 64'h1, 64'h2, 64'h1, 64'h2, st, ov);
    send(5'd1, 5'd1, 5'd8, 1, 1, 1, 0, 64'h3, 64'h3, 64'h3, 64'h3, st, ov);
    send(5'd6, 5'd1, 5'd9, 0, 1, 1, 0, 64'h66, 64'h6, 64'h0, 64'h6, st, ov);
    check("unused_op_stall", 64'(st), 64'd0);

    // Backpressure: hold for 3 cycles with the next instruction waiting.
    send(5'd1, 5'd2, 5'd14, 1, 1, 1, 0, 64'h61, 64'h62, 64'h61, 64'h62, st, ov);
    out_ready = 1'b0;
    in_rn = 5'd3; in_rm = 5'd4; in_uses_rn = 1'b1; in_uses_rm = 1'b1;
    rf_read_data1 = 64'hF1; rf_read_data2 = 64'hF2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_op_a", out_op_a, 64'h61);
      check("bp_op_b", out_op_b, 64'h62);
      check("bp_rd", 64'(out_rd), 64'd14);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5'd3, 5'd4, 5'd15, 1, 1, 1, 0, 64'hF1, 64'hF2, 64'hF1, 64'hF2, st, ov);
    check("bp_release_stall", 64'(st), 64'd0);

    // Flush while a load is handed off: its tracking is cancelled.
    send(5'd1, 5'd2, 5'd7, 1, 1, 1, 1, 64'h1, 64'h2, 64'h1, 64'h2, st, ov);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    send(5'd7, 5'd1, 5'd9, 1, 1, 1, 0, 64'h70, 64'h6, 64'h70, 64'h6, st, ov);
    check("fl_reader_stall", 64'(st), 64'd0);

    // Reset mid-hold drops out_valid without a clock edge.
    send(5'd1, 5'd2, 5'd16, 1, 1, 1, 0, 64'h71, 64'h72, 64'h71, 64'h72, st, ov);
    out_ready = 1'b0;
    @(negedge clk);
    check("hold_before_reset", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_op_a", out_op_a, 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(5'd1, 5'd2, 5'd17, 1, 1, 1, 0, 64'h5, 64'h7, 64'h5, 64'h7, st, ov);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

The operand stage sits directly downstream of the register file, between instruction decode and execute. It drives the register file's two read addresses and takes the raw read data. It resolves each operand by priority: X31 zero, then MEM-stage forward, then write-back bypass, then register-file data. The write-back bypass closes the same-cycle write/read gap in the register file. The stage registers the resolved operands into a valid/ready pipeline register and inserts load-use bubbles.

## Interface
Parameters:
- REG_WIDTH, 64, operand/data width in bits
- NUM_REGS, 32, architectural registers; register NUM_REGS-1 (X31) always reads zero
- LOAD_STALL, 1, bubble cycles after a load before its rd may be consumed (1..3)

Ports (AW = $clog2(NUM_REGS)):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- flush  in  1  synchronous kill of held instruction and load tracking
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rn, in_rm, in_rd  in  AW each  source/destination register numbers
- in_uses_rn, in_uses_rm  in  1 each  operand actually read
- in_writes_rd, in_is_load  in  1 each  instruction writes rd / is a load
- rf_read_reg1, rf_read_reg2  out  AW each  register-file read addresses (= in_rn, in_rm, combinational)
- rf_read_data1, rf_read_data2  in  REG_WIDTH each  register-file read data
- mem_fwd_valid  in  1  MEM-stage non-load ALU result available
- mem_fwd_reg  in  AW  destination register of that result
- mem_fwd_data  in  REG_WIDTH  value of that result
- wb_write  in  1  write-back stage writes this cycle (same signal as regfile RegWrite)
- wb_reg  in  AW  write-back destination register
- wb_data  in  REG_WIDTH  write-back value
- out_valid  out  1  resolved instruction held
- out_ready  in  1  execute stage accepts
- out_op_a, out_op_b  out  REG_WIDTH each  resolved operands
- out_rd  out  AW  passed-through destination register
- out_writes_rd, out_is_load  out  1 each  passed-through control bits

## Operation
- Operand resolve, per operand, priority order:
  - Register X31 or operand unused: result is 0.
  - mem_fwd_valid and mem_fwd_reg matches: result is mem_fwd_data.
  - wb_write and wb_reg matches: result is wb_data.
  - Otherwise: result is rf_read_data.
- Load tracking: an out handshake with out_is_load=1, out_writes_rd=1 and out_rd≠X31 sets load_cnt=LOAD_STALL and load_rd=out_rd. load_cnt decrements each cycle while nonzero.
- Hazard: load_cnt≠0, and in_uses_rn with in_rn==load_rd or in_uses_rm with in_rm==load_rd. A hazard forces in_ready=0.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Capture on in_valid & in_ready: operands and control fields load and out_valid=1.
- Out handshake without a new capture: out_valid=0, which is the bubble.
- Held instruction: out_valid=1 & !out_ready keeps all outputs stable; operands are not re-resolved.
- flush: next edge out_valid=0 and load_cnt=0; no capture that cycle.
- Simultaneous out handshake of a load and input capture: the new instruction is checked against the previous load_rd only. The new load's tracking starts next cycle; downstream ordering guarantees this.

## Timing
- Reset (reset=0): out_valid=0, out_op_a=out_op_b=0, out_rd=0, out_writes_rd=out_is_load=0, load_cnt=0, load_rd=0.
- Reset released: in_ready=1 in the first cycle.
- Latency: one cycle from input capture to out_valid.
- Throughput: one instruction per cycle with no hazards.
- Load-use cost: exactly LOAD_STALL bubble cycles after the load's out handshake.
- in_ready, rf_read_reg1 and rf_read_reg2 are combinational. All other outputs are registered.
- Reset asserted mid-stall: the stall is abandoned and out_valid drops asynchronously.

## Structure
- Shared package cpu_pkg:
  - reg_addr_t typedef.
  - XZR constant (NUM_REGS-1).
  - op_ctrl_t struct {rd, writes_rd, is_load}.
- Sub-module operand_bypass, instantiated twice:
  - Purely combinational priority mux.
  - Ports: reg number, uses, rf data, mem forward triple, wb triple; output: resolved value.

## Test plan
- Reset with out_ready=1:
  - After reset release, out_valid=0 and in_ready=1.
  - Capture rn=1 (rf=0x5), rm=2 (rf=0x7) → next cycle out_op_a=0x5, out_op_b=0x7.
- Same-cycle WB bypass: wb_write=1, wb_reg=3, wb_data=0xAA, in_rn=3, rf_read_data1=0x11 → out_op_a=0xAA.
- Forward priority: mem_fwd reg 4 = 0x22 and wb reg 4 = 0x33, in_rn=4 → out_op_a=0x22. in_rn=31 with both forwarding 31 → out_op_a=0.
- Load-use, LOAD_STALL=1:
  - Load to X5 handed off, next instruction reads X5 → in_ready=0 for exactly 1 cycle, out_valid=0 for 1 cycle, then capture.
  - Load to X31 or an unused operand → no stall.
- Backpressure: out_ready=0 for 3 cycles → outputs stable and in_ready=0. Raising out_ready accepts the next instruction the same cycle.
- Flush and reset:
  - flush during a pending load stall → out_valid=0, the following reader is accepted immediately.
  - reset low mid-hold → out_valid=0 without a clock edge.
